// File: rtl/uart_rx_deframer_if.sv
// Serial receiver bundle: the raw line in, plus the parallel byte and strobes out.
// The master side (host/line model) drives rx; the slave side (the deframer)
// drives the byte, strobes and busy flag.
`timescale 1ns/1ps
interface uart_rx_deframer_if;
    logic       rx;
    logic [7:0] RX_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx,
        input  RX_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output RX_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 serial deframer, LSB first. The line is synchronised, run through a
// 3-sample majority filter, and sampled at bit centres. Good bytes update a
// held RX_data bus with a one-cycle rx_valid; a low stop bit yields a one-cycle
// frame_err and the byte is dropped. A start bit that is not still low at its
// half-bit point is treated as a glitch and ignored.
`timescale 1ns/1ps
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_rx_deframer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Two-of-three vote used as the filtered bit value.
    function automatic logic majority3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic [2:0]       hist_r;
    logic             rx_s;
    logic             bit_s;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic [7:0]       data_r;
    logic [7:0]       data_s;
    logic             valid_r;
    logic             valid_s;
    logic             ferr_r;
    logic             ferr_s;
    logic             busy_r;

    assign rx_s  = sync2_r;
    assign bit_s = majority3(hist_r);

    // Bring the asynchronous line into the clock domain and keep a short sample history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            hist_r  <= 3'b111;
        end else begin
            sync1_r <= bus.rx;
            sync2_r <= sync1_r;
            hist_r  <= {hist_r[1:0], rx_s};
        end
    end

    // Frame sequencing: next state, counters, shift register and strobes.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        data_s    = data_r;
        valid_s   = 1'b0;
        ferr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s     = CNT_ZERO;
                bit_idx_s = 3'd0;
                if (!rx_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s = CNT_ZERO;
                    if (!bit_s) begin
                        state_s   = DATA;
                        bit_idx_s = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s     = CNT_ZERO;
                    shift_s   = {bit_s, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_r == FULL_M1) begin
                    // Leave at the stop-bit centre so a back-to-back start is caught.
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                    if (bit_s) begin
                        data_s  = shift_r;
                        valid_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s   = IDLE;
                cnt_s     = CNT_ZERO;
                bit_idx_s = 3'd0;
            end
        endcase
    end

    // Register FSM state, datapath and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            ferr_r    <= ferr_s;
            busy_r    <= (state_s != IDLE);
        end
    end

    assign bus.RX_data   = data_r;
    assign bus.rx_valid  = valid_r;
    assign bus.frame_err = ferr_r;
    assign bus.rx_busy   = busy_r;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer at 16 clocks per bit. A line driver plays whole
// 8N1 frames; for each frame the expected outcome (good byte or framing error,
// the value RX_data must show, and the due cycle) is queued when it starts.
// A monitor pops and compares whenever a strobe appears.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

    localparam int CPB     = 16;
    localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk;
    logic rst_n;
    uart_rx_deframer_if bus_if ();

    uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    exp_t       sbq[$];
    logic [7:0] model_last = 8'h00;
    bit         prev_strobe = 1'b0;
    int         vcyc_last = 0;
    int         vcyc_prev = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every strobe is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = 1'b0;
        end else begin
            if (bus_if.rx_valid || bus_if.frame_err) begin
                exp_t e;
                chk("both_strobes", {31'd0, bus_if.rx_valid & bus_if.frame_err}, 32'd0);
                chk("strobe_gap", {31'd0, prev_strobe}, 32'd0);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe valid=%0b ferr=%0b data=%0h at cycle %0d required=none",
                             bus_if.rx_valid, bus_if.frame_err, bus_if.RX_data, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("strobe_kind_ferr", {31'd0, bus_if.frame_err}, {31'd0, e.is_err});
                    chk("rx_data", {24'd0, bus_if.RX_data}, {24'd0, e.data});
                    total++;
                    if (cyc < e.due - 1 || cyc > e.due + 1) begin
                        bad++;
                        $display("FAIL latency actual_cycle=%0d required=%0d+-1", cyc, e.due);
                    end
                end
                if (bus_if.rx_valid) begin
                    vcyc_prev = vcyc_last;
                    vcyc_last = cyc;
                end
            end
            prev_strobe = bus_if.rx_valid | bus_if.frame_err;
        end
    end

    // One serial slot of n cycles; optional single-cycle inversion near the centre.
    task automatic drive_slot(input logic v, input bit gl, input int n);
        for (int j = 0; j < n; j++) begin
            bus_if.rx = (gl && j == 7) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        bus_if.rx = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gl: -1 none, 0 start bit, 1..8 data bit gl-1, 9 stop bit.
    // A bad stop holds the line low across the stop centre only, then high.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gl);
        exp_t e;
        e.due    = cyc + LATENCY;
        e.is_err = !stop_ok;
        e.data   = stop_ok ? b : model_last;
        if (stop_ok) model_last = b;
        sbq.push_back(e);
        drive_slot(1'b0, gl == 0, CPB);
        for (int i = 0; i < 8; i++) drive_slot(b[i], gl == i + 1, CPB);
        if (stop_ok) begin
            drive_slot(1'b1, gl == 9, CPB);
        end else begin
            drive_slot(1'b0, gl == 9, 9);
            drive_slot(1'b1, 1'b0, CPB - 9);
        end
        bus_if.rx = 1'b1;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s pending_expectations=%0d required=0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int bcnt;
        int g;
        logic [7:0] rb;
        bus_if.rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_data", {24'd0, bus_if.RX_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, bus_if.rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
        chk("reset_rx_busy", {31'd0, bus_if.rx_busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(10);
        chk("idle_busy", {31'd0, bus_if.rx_busy}, 32'd0);

        // Single ideal byte.
        send_frame(8'h0F, 1'b1, -1);
        wait_drain("drain_0x0f", 300);
        idle(5);

        // Back-to-back frames, 160 cycles apart.
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'hA5, 1'b1, -1);
        wait_drain("drain_b2b", 300);
        total++;
        if (vcyc_last - vcyc_prev < 10 * CPB - 1 || vcyc_last - vcyc_prev > 10 * CPB + 1) begin
            bad++;
            $display("FAIL b2b_spacing actual=%0d required=%0d+-1", vcyc_last - vcyc_prev, 10 * CPB);
        end
        idle(5);

        // Short low pulse on an idle line: start rejected, no strobes.
        bus_if.rx = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus_if.rx = 1'b1;
        bcnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus_if.rx_busy) bcnt++;
        end
        @(posedge clk);
        #1;
        total++;
        if (bcnt < 1 || bcnt > 10) begin
            bad++;
            $display("FAIL start_glitch_busy actual=%0d required=1..10", bcnt);
        end
        chk("start_glitch_idle", {31'd0, bus_if.rx_busy}, 32'd0);

        // Framing error then a good byte.
        send_frame(8'h3C, 1'b0, -1);
        idle(20);
        send_frame(8'h55, 1'b1, -1);
        wait_drain("drain_ferr", 400);
        idle(5);

        // Glitch at the bit-3 centre of 0x00 is voted out.
        send_frame(8'h00, 1'b1, 4);
        wait_drain("drain_glitch", 300);
        idle(5);

        // Randomized frames: random byte, gap, glitch position and stop quality.
        for (int n = 0; n < 14; n++) begin
            rb = 8'($urandom_range(0, 255));
            g  = $urandom_range(0, 14);
            send_frame(rb, $urandom_range(0, 3) != 0, (g <= 9) ? g : -1);
            idle($urandom_range(0, 12));
        end
        wait_drain("drain_random", 400);
        idle(5);

        // Reset in the middle of bit 4 abandons the byte.
        send_frame(8'hC3, 1'b1, -1);
        wait_drain("drain_pre_reset", 300);
        idle(5);
        drive_slot(1'b0, 1'b0, CPB);
        drive_slot(1'b1, 1'b0, CPB);
        drive_slot(1'b0, 1'b0, CPB);
        drive_slot(1'b1, 1'b0, CPB);
        drive_slot(1'b1, 1'b0, CPB);
        drive_slot(1'b0, 1'b0, CPB / 2);
        rst_n = 1'b0;
        model_last = 8'h00;
        @(negedge clk);
        chk("midreset_rx_data", {24'd0, bus_if.RX_data}, 32'd0);
        chk("midreset_rx_valid", {31'd0, bus_if.rx_valid}, 32'd0);
        chk("midreset_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
        chk("midreset_rx_busy", {31'd0, bus_if.rx_busy}, 32'd0);
        bus_if.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3 * CPB);
        chk("post_reset_idle", {31'd0, bus_if.rx_busy}, 32'd0);
        send_frame(8'h81, 1'b1, -1);
        wait_drain("drain_0x81", 300);
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog run did not complete");
        $fatal(1, "watchdog");
    end

endmodule
